// File: rtl/host_cmd_axil_bridge_if.sv
// AXI-lite register port plus single-cycle host command port of host_cmd_axil_bridge.
// The slave modport is the bridge side; the master modport is the host/consumer side.
interface host_cmd_axil_bridge_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] s_axil_awaddr;
    logic                  s_axil_awvalid;
    logic                  s_axil_awready;
    logic [31:0]           s_axil_wdata;
    logic [3:0]            s_axil_wstrb;
    logic                  s_axil_wvalid;
    logic                  s_axil_wready;
    logic [1:0]            s_axil_bresp;
    logic                  s_axil_bvalid;
    logic                  s_axil_bready;
    logic [ADDR_WIDTH-1:0] s_axil_araddr;
    logic                  s_axil_arvalid;
    logic                  s_axil_arready;
    logic [31:0]           s_axil_rdata;
    logic [1:0]            s_axil_rresp;
    logic                  s_axil_rvalid;
    logic                  s_axil_rready;
    logic [31:0]           host_cmd;
    logic [31:0]           host_cmd_wr_data;
    logic                  host_cmd_valid;
    logic [31:0]           host_cmd_rd_data;

    modport slave (
        input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        input  s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready, host_cmd_rd_data,
        output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
        output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        output host_cmd, host_cmd_wr_data, host_cmd_valid
    );

    modport master (
        output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        output s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready, host_cmd_rd_data,
        input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
        input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        input  host_cmd, host_cmd_wr_data, host_cmd_valid
    );
endinterface

// File: rtl/host_cmd_axil_bridge.sv
// AXI-lite slave issuing single-cycle host commands and capturing read data after RD_LATENCY.
// Define HOST_CMD_COUNTER_EN to expose a 16-bit issued-command count in STATUS[31:16].
module host_cmd_axil_bridge #(
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LATENCY = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    host_cmd_axil_bridge_if.slave bus
);
    localparam logic [1:0] REG_CMD     = 2'd0;
    localparam logic [1:0] REG_WR_DATA = 2'd1;
    localparam logic [1:0] REG_RD_DATA = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;
    localparam logic [7:0] LAT_M1      = 8'(RD_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] host_cmd_q, host_cmd_d;
    logic [31:0] cmd_wr_data_q, cmd_wr_data_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] status;
    logic [1:0]  aw_sel, ar_sel;
    logic        wr_hs, ar_hs, cmd_issue, issue_cycle;
    logic [ADDR_WIDTH-1:0] unused_addr;

    assign aw_sel      = bus.s_axil_awaddr[3:2];
    assign ar_sel      = bus.s_axil_araddr[3:2];
    assign unused_addr = bus.s_axil_awaddr ^ bus.s_axil_araddr;

    // CMD writes and RD_DATA reads hold off while a command is in flight
    assign wr_hs = bus.s_axil_awvalid && bus.s_axil_wvalid && !bvalid_q &&
                   !(aw_sel == REG_CMD && busy_q);
    assign ar_hs = bus.s_axil_arvalid && !rvalid_q && !(ar_sel == REG_RD_DATA && busy_q);
    assign cmd_issue = wr_hs && aw_sel == REG_CMD && bus.s_axil_wstrb == 4'hF;

`ifdef HOST_CMD_COUNTER_EN
    logic [15:0] issued_q, issued_d;
    assign issued_d = issue_cycle ? issued_q + 16'd1 : issued_q;
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) issued_q <= 16'd0;
        else         issued_q <= issued_d;
    end
    assign status = {issued_q, 14'd0, rd_valid_q, busy_q};
`else
    assign status = {16'd0, 14'd0, rd_valid_q, busy_q};
`endif

    // FSM: state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_issue) state_d = S_ISSUE;
            S_ISSUE: state_d = host_cmd_q[31] ? S_IDLE : S_WAIT;
            S_WAIT:  if (cnt_q == 8'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        issue_cycle = (state_q == S_ISSUE);
    end

    always_comb begin
        busy_d        = busy_q;
        rd_valid_d    = rd_valid_q;
        host_cmd_d    = host_cmd_q;
        cmd_wr_data_d = cmd_wr_data_q;
        wr_data_d     = wr_data_q;
        rd_data_d     = rd_data_q;
        cnt_d         = cnt_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        rvalid_d      = rvalid_q;
        rdata_d       = rdata_q;

        if (cmd_issue) begin
            host_cmd_d    = bus.s_axil_wdata;
            cmd_wr_data_d = wr_data_q;
            busy_d        = 1'b1;
            rd_valid_d    = 1'b0;
        end
        if (wr_hs && aw_sel == REG_WR_DATA) begin
            for (int i = 0; i < 4; i++)
                if (bus.s_axil_wstrb[i]) wr_data_d[8*i +: 8] = bus.s_axil_wdata[8*i +: 8];
        end

        case (state_q)
            S_ISSUE: begin
                if (host_cmd_q[31]) busy_d = 1'b0;
                else                cnt_d  = LAT_M1;
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    rd_data_d  = bus.host_cmd_rd_data;
                    rd_valid_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: ;
        endcase

        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = (aw_sel == REG_CMD && bus.s_axil_wstrb != 4'hF) ? 2'b10 : 2'b00;
        end else if (bvalid_q && bus.s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        // read data reflects register state before any same-cycle write
        if (ar_hs) begin
            rvalid_d = 1'b1;
            case (ar_sel)
                REG_CMD:     rdata_d = host_cmd_q;
                REG_WR_DATA: rdata_d = wr_data_q;
                REG_RD_DATA: rdata_d = rd_data_q;
                default:     rdata_d = status;
            endcase
        end else if (rvalid_q && bus.s_axil_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            busy_q        <= 1'b0;
            rd_valid_q    <= 1'b0;
            host_cmd_q    <= 32'd0;
            cmd_wr_data_q <= 32'd0;
            wr_data_q     <= 32'd0;
            rd_data_q     <= 32'd0;
            cnt_q         <= 8'd0;
            bvalid_q      <= 1'b0;
            bresp_q       <= 2'b00;
            rvalid_q      <= 1'b0;
            rdata_q       <= 32'd0;
        end else begin
            busy_q        <= busy_d;
            rd_valid_q    <= rd_valid_d;
            host_cmd_q    <= host_cmd_d;
            cmd_wr_data_q <= cmd_wr_data_d;
            wr_data_q     <= wr_data_d;
            rd_data_q     <= rd_data_d;
            cnt_q         <= cnt_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
        end
    end

    assign bus.s_axil_awready   = wr_hs;
    assign bus.s_axil_wready    = wr_hs;
    assign bus.s_axil_bvalid    = bvalid_q;
    assign bus.s_axil_bresp     = bresp_q;
    assign bus.s_axil_arready   = ar_hs;
    assign bus.s_axil_rvalid    = rvalid_q;
    assign bus.s_axil_rdata     = rdata_q;
    assign bus.s_axil_rresp     = 2'b00;
    assign bus.host_cmd         = host_cmd_q;
    assign bus.host_cmd_wr_data = cmd_wr_data_q;
    assign bus.host_cmd_valid   = issue_cycle;
endmodule

// File: doc/host_cmd_axil_bridge.md
Name: host_cmd_axil_bridge

Overview:
- AXI-lite slave that turns host register accesses into the single-cycle host command interface of the command/status subsystem: host_cmd, host_cmd_wr_data, host_cmd_valid and host_cmd_rd_data.
- Sits directly upstream of the command/status subsystem in the sys_clk domain, between the PCIe AXI-lite register space and the command consumer.
- For read commands it waits a fixed round-trip latency, then captures the returned data into a host-readable register.

Parameters:
- ADDR_WIDTH, 4, AXI-lite address width; only addr[3:2] is decoded.
- RD_LATENCY, 16, cycles from host_cmd_valid to the cycle host_cmd_rd_data is sampled; legal range 1..255.

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-high
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awvalid / s_axil_awready  in / out  1  AW handshake
- s_axil_wdata  in  32  write data
- s_axil_wstrb  in  4  byte strobes
- s_axil_wvalid / s_axil_wready  in / out  1  W handshake
- s_axil_bresp  out  2  write response
- s_axil_bvalid / s_axil_bready  out / in  1  B handshake
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_arvalid / s_axil_arready  in / out  1  AR handshake
- s_axil_rdata  out  32  read data
- s_axil_rresp  out  2  read response, always OKAY
- s_axil_rvalid / s_axil_rready  out / in  1  R handshake
- host_cmd  out  32  command word; bit31 = WR, bits30:29 = target
- host_cmd_wr_data  out  32  command write data
- host_cmd_valid  out  1  one-cycle command strobe
- host_cmd_rd_data  in  32  readback from the command consumer

Behaviour:
- Reset (async, active-high): all *ready/*valid outputs, host_cmd_valid, busy and rd_valid = 0; host_cmd, host_cmd_wr_data, RD_DATA and the counter = 0; FSM = IDLE.
- Register map (addr[3:2]):
  - 0 CMD: write issues a command; read returns the last host_cmd.
  - 1 WR_DATA: byte-strobed write; read returns the value.
  - 2 RD_DATA: read-only.
  - 3 STATUS: read-only; bit0 busy, bit1 rd_valid, bits31:16 counter (see Optional Feature).
- Write channel:
  - awready and wready are asserted together for one cycle only when awvalid && wvalid && !bvalid, and not (addr==CMD && busy). A CMD write therefore stalls while busy.
  - bvalid rises the cycle after the handshake and holds until bready.
- Writes to CMD:
  - wstrb must be 4'hF; otherwise bresp = SLVERR (2'b10) and no issue.
  - A valid CMD write is OKAY and takes effect in the handshake cycle: host_cmd <= wdata, busy <= 1, rd_valid <= 0.
  - Writes to RD_DATA/STATUS are ignored and return OKAY.
- Command FSM:
  - IDLE -> ISSUE on a valid CMD write.
  - ISSUE: host_cmd_valid = 1 for exactly one cycle (cycle T). host_cmd_wr_data holds the WR_DATA value. If host_cmd[31] = 1, go to IDLE and clear busy at T+1. Otherwise load count = RD_LATENCY-1 and go to WAIT.
  - WAIT: decrement each cycle. When count == 0 (cycle T+RD_LATENCY): RD_DATA <= host_cmd_rd_data, rd_valid <= 1, go to IDLE. busy clears at T+RD_LATENCY+1.
- Read channel:
  - arready is asserted for one cycle when arvalid && !rvalid, and not (addr==RD_DATA && busy). An RD_DATA read stalls while busy.
  - rdata is registered and rvalid rises the next cycle, holding until rready.
- host_cmd and host_cmd_wr_data stay stable outside ISSUE.
- A WR_DATA write during busy is accepted; it affects only the next command.
- Simultaneous AXI read and write are independent. A STATUS read in the CMD-write handshake cycle returns the pre-write status.
- Reset mid-WAIT aborts the command with no capture.

Optional Feature:
- Macro HOST_CMD_COUNTER_EN.
- Defined: STATUS[31:16] is a 16-bit count of issued commands. It increments in each ISSUE cycle, wraps 0xFFFF -> 0x0000, and resets to 0.
- Undefined: STATUS[31:16] reads 0 and no counter logic is built.

Test Plan:
- Reset, then read STATUS -> 0x00000000; host_cmd_valid stays 0.
- Write WR_DATA = 0x0000_0005, write CMD = 0xA000_0000 -> exactly one host_cmd_valid pulse with host_cmd = 0xA0000000 and host_cmd_wr_data = 5; STATUS = 0 two cycles later.
- RD_LATENCY = 16, write CMD = 0x2000_0040, host_cmd_rd_data = 0x1234_5678 at T+16 and 0 elsewhere -> RD_DATA reads 0x12345678; STATUS bit1 = 1.
- Issue a read command, then immediately read RD_DATA -> arready stays low until T+17; returned data = captured value. A second CMD write during WAIT gets no awready until idle.
- Write CMD with wstrb = 4'h3 -> bresp = 2'b10, no host_cmd_valid, STATUS unchanged.
- With HOST_CMD_COUNTER_EN: preload via 65537 write commands -> STATUS[31:16] = 0x0001. Without the macro -> 0x0000.
